// File: rtl/scm_port_arbiter.sv
// scm_port_arbiter: shares the single read and single write port of a 1R1W
// standard-cell memory among NREQ requesters with independent round-robin
// arbitration per port, zero-initialises all rows after reset or on CLR,
// and stalls a read that targets the row being written in the same cycle.
module scm_port_arbiter #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       SCAN_EN,
  input  logic                       CLR,
  input  logic [NREQ-1:0]            REQ_VALID,
  input  logic [NREQ-1:0]            REQ_WE,
  input  logic [NREQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NREQ*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [NREQ-1:0]            REQ_READY,
  output logic                       RSP_VALID,
  output logic [IDW-1:0]             RSP_ID,
  output logic [DATA_WIDTH-1:0]      RSP_RDATA,
  output logic                       INIT_DONE,
  output logic                       MEM_WE,
  output logic                       MEM_RE,
  output logic                       MEM_SE,
  output logic [ADDR_WIDTH-1:0]      MEM_WADDR,
  output logic [ADDR_WIDTH-1:0]      MEM_RADDR,
  output logic [DATA_WIDTH-1:0]      MEM_DIN,
  input  logic [DATA_WIDTH-1:0]      MEM_DOUT
);

  localparam int NUM_ROWS = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]          wptr_q, wptr_d;
  logic [IDW-1:0]          rptr_q, rptr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]         wreq, rreq;
  logic                    w_found, r_found;
  logic [IDW-1:0]          w_win, r_win;
  logic [ADDR_WIDTH-1:0]   w_addr, r_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    collision;
  logic                    run_active;
  logic                    w_grant, r_grant;

  // Pointer value following a winner, wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] win);
    if (int'(win) == NREQ - 1) return '0;
    return win + IDW'(1);
  endfunction

  assign wreq = REQ_VALID & REQ_WE;
  assign rreq = REQ_VALID & ~REQ_WE;

  // Write-class winner: first pending writer at or after the write pointer.
  always_comb begin : pick_write
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(wptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && wreq[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  // Read-class winner: first pending reader at or after the read pointer.
  always_comb begin : pick_read
    int idx;
    idx     = 0;
    r_found = 1'b0;
    r_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!r_found && rreq[idx]) begin
        r_found = 1'b1;
        r_win   = IDW'(idx);
      end
    end
  end

  assign w_addr = REQ_ADDR[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_data = REQ_WDATA[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
  assign r_addr = REQ_ADDR[int'(r_win)*ADDR_WIDTH +: ADDR_WIDTH];

  // A read of the row being written this cycle waits so it sees the new data.
  assign collision  = w_found && r_found && (w_addr == r_addr);
  assign run_active = (state_q == RUN) && !SCAN_EN && !CLR;
  assign w_grant    = run_active && w_found;
  assign r_grant    = run_active && r_found && !collision;

  // Per-requester ready from the two class grants.
  always_comb begin
    REQ_READY = '0;
    if (w_grant) REQ_READY[w_win] = 1'b1;
    if (r_grant) REQ_READY[r_win] = 1'b1;
  end

  // Memory port drive: init sweep owns the write port, otherwise the winners.
  always_comb begin
    MEM_SE    = SCAN_EN;
    MEM_WE    = 1'b0;
    MEM_WADDR = w_addr;
    MEM_DIN   = w_data;
    MEM_RE    = r_grant;
    MEM_RADDR = r_addr;
    if (state_q == INIT) begin
      MEM_WE    = !SCAN_EN;
      MEM_WADDR = cnt_q;
      MEM_DIN   = '0;
    end else begin
      MEM_WE = w_grant;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_RDATA = MEM_DOUT;
  assign INIT_DONE = (state_q == RUN);

  // Next-state, init counter, RR pointers and response tracking; scan freezes all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rsp_valid_d = r_grant;
    rsp_id_d    = r_grant ? r_win : rsp_id_q;
    if (!SCAN_EN) begin
      case (state_q)
        IDLE: begin
          state_d = INIT;
          cnt_d   = '0;
        end
        INIT: begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == ADDR_WIDTH'(NUM_ROWS - 1)) state_d = RUN;
        end
        RUN: begin
          if (CLR) begin
            state_d = INIT;
            cnt_d   = '0;
          end
          if (w_grant) wptr_d = rr_next(w_win);
          if (r_grant) rptr_d = rr_next(r_win);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_scm_port_arbiter.sv
// tb_scm_port_arbiter: drives scm_port_arbiter against a behavioural 1R1W
// memory, checking init sweeps, round-robin grants, collisions, reset,
// scan freeze and CLR re-initialisation. Read responses are scoreboarded.
module tb_scm_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 6;
  localparam int DW   = 64;
  localparam int ROWS = 64;

  typedef struct packed {
    logic [0:0]    id;
    logic [DW-1:0] data;
  } rsp_t;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               SCAN_EN;
  logic               CLR;
  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ-1:0]    REQ_WE;
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_WDATA;
  logic [NREQ-1:0]    REQ_READY;
  logic               RSP_VALID;
  logic [0:0]         RSP_ID;
  logic [DW-1:0]      RSP_RDATA;
  logic               INIT_DONE;
  logic               MEM_WE, MEM_RE, MEM_SE;
  logic [AW-1:0]      MEM_WADDR, MEM_RADDR;
  logic [DW-1:0]      MEM_DIN;
  logic [DW-1:0]      MEM_DOUT;

  logic [DW-1:0] mem_array [ROWS];
  logic [DW-1:0] model_mem [ROWS];
  logic          fill;
  rsp_t          sb_q[$];
  rsp_t          exp_rsp;
  int            vectors;
  int            miscompares;

  scm_port_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .SCAN_EN(SCAN_EN), .CLR(CLR),
    .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_RDATA(RSP_RDATA),
    .INIT_DONE(INIT_DONE), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_SE(MEM_SE),
    .MEM_WADDR(MEM_WADDR), .MEM_RADDR(MEM_RADDR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural 1R1W memory; fill preloads non-zero garbage before init.
  always @(posedge CLK) begin
    if (fill) begin
      for (int i = 0; i < ROWS; i++) mem_array[i] <= {32'hDEADBEEF, 32'(i)};
    end else begin
      if (MEM_WE) mem_array[MEM_WADDR] <= MEM_DIN;
      if (MEM_RE) MEM_DOUT <= mem_array[MEM_RADDR];
    end
  end

  // Runaway guard so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_VALID[id]          = v;
    REQ_WE[id]             = we;
    REQ_ADDR[id*AW +: AW]  = a;
    REQ_WDATA[id*DW +: DW] = d;
  endtask

  task automatic test_init_sweep(input string tag);
    set_req(0, 1'b1, 1'b0, 6'd1, '0);
    set_req(1, 1'b1, 1'b0, 6'd2, '0);
    #1;
    for (int i = 0; i < ROWS; i++) begin
      vectors++;
      if ({MEM_WE, MEM_RE, MEM_WADDR, REQ_READY, INIT_DONE} !== {1'b1, 1'b0, 6'(i), 2'b00, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL %s_sweep row %0d: got we=%b re=%b waddr=%0d ready=%b done=%b, want we=1 re=0 waddr=%0d ready=00 done=0",
                 tag, i, MEM_WE, MEM_RE, MEM_WADDR, REQ_READY, INIT_DONE, i);
      end
      vectors++;
      if (MEM_DIN !== '0) begin
        miscompares++;
        $display("[TB] FAIL %s_sweep_din row %0d: got %h, want 0", tag, i, MEM_DIN);
      end
      if (i == ROWS - 1) REQ_VALID = '0;
      tick();
    end
    vectors++;
    if ({INIT_DONE, REQ_READY, MEM_WE} !== {1'b1, 2'b00, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL %s_done: got done=%b ready=%b we=%b, want done=1 ready=00 we=0",
               tag, INIT_DONE, REQ_READY, MEM_WE);
    end
    for (int i = 0; i < ROWS; i++) model_mem[i] = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; SCAN_EN = 1'b0; CLR = 1'b0;
    REQ_VALID = 2'b11; REQ_WE = 2'b01; REQ_ADDR = '0; REQ_WDATA = '1;
    fill = 1'b1;
    repeat (3) @(negedge CLK);
    fill = 1'b0;
    #1;
    vectors++;
    if ({INIT_DONE, REQ_READY, MEM_WE, MEM_RE, RSP_VALID, RSP_ID} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got done=%b ready=%b we=%b re=%b rv=%b rid=%b, want all 0",
               INIT_DONE, REQ_READY, MEM_WE, MEM_RE, RSP_VALID, RSP_ID);
    end
    REQ_VALID = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    vectors++;
    if ({MEM_WE, MEM_RE, INIT_DONE} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_cycle: got we=%b re=%b done=%b, want 000", MEM_WE, MEM_RE, INIT_DONE);
    end
    tick();
    test_init_sweep("reset");
  endtask

  task automatic test_readback(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [AW-1:0] addrs [3];
    addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 1'b0, addrs[k], '0);
      #1;
      vectors++;
      if ({REQ_READY, MEM_RE, MEM_RADDR} !== {2'b01, 1'b1, addrs[k]}) begin
        miscompares++;
        $display("[TB] FAIL readback_issue: got ready=%b re=%b raddr=%0d, want ready=01 re=1 raddr=%0d",
                 REQ_READY, MEM_RE, MEM_RADDR, addrs[k]);
      end
      sb_q.push_back('{id: 1'b0, data: model_mem[addrs[k]]});
      tick();
      REQ_VALID = '0;
      #1;
      vectors++;
      if (!(RSP_VALID === 1'b1 && sb_q.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL readback_rsp_valid: got %b (queued %0d), want 1", RSP_VALID, sb_q.size());
      end else begin
        exp_rsp = sb_q.pop_front();
        vectors++;
        if ({RSP_ID, RSP_RDATA} !== {exp_rsp.id, exp_rsp.data}) begin
          miscompares++;
          $display("[TB] FAIL readback_rsp row %0d: got id=%0d data=%h, want id=%0d data=%h",
                   addrs[k], RSP_ID, RSP_RDATA, exp_rsp.id, exp_rsp.data);
        end
      end
    end
  endtask

  task automatic test_write_rr();
    logic [DW-1:0] d5, d9;
    d5 = 64'h0505_0505_0505_0505;
    d9 = 64'h0909_0909_0909_0909;
    set_req(0, 1'b1, 1'b1, 6'd5, d5);
    set_req(1, 1'b1, 1'b1, 6'd9, d9);
    #1;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if ({REQ_READY, MEM_WE, MEM_WADDR, MEM_DIN} !==
          {(c % 2 == 0) ? 2'b01 : 2'b10, 1'b1, (c % 2 == 0) ? 6'd5 : 6'd9, (c % 2 == 0) ? d5 : d9}) begin
        miscompares++;
        $display("[TB] FAIL write_rr cycle %0d: got ready=%b we=%b waddr=%0d din=%h, want ready=%s waddr=%0d",
                 c, REQ_READY, MEM_WE, MEM_WADDR, MEM_DIN, (c % 2 == 0) ? "01" : "10", (c % 2 == 0) ? 5 : 9);
      end
      tick();
    end
    model_mem[5] = d5;
    model_mem[9] = d9;
    REQ_VALID = '0;
    set_req(0, 1'b1, 1'b1, 6'd11, '0);
    set_req(1, 1'b1, 1'b1, 6'd12, '0);
    #1;
    vectors++;
    if (REQ_READY !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL write_ptr_wrap: got ready=%b, want 01", REQ_READY);
    end
    REQ_VALID = '0;
    #1;
  endtask

  task automatic test_collision();
    set_req(0, 1'b1, 1'b1, 6'd3, 64'hA5A5_A5A5_A5A5_A5A5);
    set_req(1, 1'b1, 1'b0, 6'd3, '0);
    #1;
    vectors++;
    if ({REQ_READY, MEM_WE, MEM_WADDR, MEM_RE} !== {2'b01, 1'b1, 6'd3, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL collision_stall: got ready=%b we=%b waddr=%0d re=%b, want ready=01 we=1 waddr=3 re=0",
               REQ_READY, MEM_WE, MEM_WADDR, MEM_RE);
    end
    tick();
    model_mem[3] = 64'hA5A5_A5A5_A5A5_A5A5;
    REQ_VALID[0] = 1'b0;
    #1;
    vectors++;
    if ({RSP_VALID, REQ_READY, MEM_RE, MEM_RADDR} !== {1'b0, 2'b10, 1'b1, 6'd3}) begin
      miscompares++;
      $display("[TB] FAIL collision_retry: got rv=%b ready=%b re=%b raddr=%0d, want rv=0 ready=10 re=1 raddr=3",
               RSP_VALID, REQ_READY, MEM_RE, MEM_RADDR);
    end
    sb_q.push_back('{id: 1'b1, data: model_mem[3]});
    tick();
    REQ_VALID = '0;
    #1;
    vectors++;
    if (!(RSP_VALID === 1'b1 && sb_q.size() != 0)) begin
      miscompares++;
      $display("[TB] FAIL collision_rsp_valid: got %b (queued %0d), want 1", RSP_VALID, sb_q.size());
    end else begin
      exp_rsp = sb_q.pop_front();
      vectors++;
      if ({RSP_ID, RSP_RDATA} !== {exp_rsp.id, exp_rsp.data}) begin
        miscompares++;
        $display("[TB] FAIL collision_rsp: got id=%0d data=%h, want id=%0d data=%h",
                 RSP_ID, RSP_RDATA, exp_rsp.id, exp_rsp.data);
      end
    end
  endtask

  task automatic test_parallel();
    set_req(0, 1'b1, 1'b1, 6'd20, 64'h2020_0000_C0DE_0020);
    #1;
    vectors++;
    if (REQ_READY !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL parallel_prefill: got ready=%b, want 01", REQ_READY);
    end
    tick();
    model_mem[20] = 64'h2020_0000_C0DE_0020;
    set_req(0, 1'b1, 1'b1, 6'd10, 64'h1010_1010_1010_1010);
    set_req(1, 1'b1, 1'b0, 6'd20, '0);
    #1;
    vectors++;
    if ({REQ_READY, MEM_WE, MEM_WADDR, MEM_RE, MEM_RADDR} !== {2'b11, 1'b1, 6'd10, 1'b1, 6'd20}) begin
      miscompares++;
      $display("[TB] FAIL parallel_issue: got ready=%b we=%b waddr=%0d re=%b raddr=%0d, want ready=11 waddr=10 raddr=20",
               REQ_READY, MEM_WE, MEM_WADDR, MEM_RE, MEM_RADDR);
    end
    sb_q.push_back('{id: 1'b1, data: model_mem[20]});
    tick();
    model_mem[10] = 64'h1010_1010_1010_1010;
    REQ_VALID = '0;
    #1;
    vectors++;
    if (!(RSP_VALID === 1'b1 && sb_q.size() != 0)) begin
      miscompares++;
      $display("[TB] FAIL parallel_rsp_valid: got %b (queued %0d), want 1", RSP_VALID, sb_q.size());
    end else begin
      exp_rsp = sb_q.pop_front();
      vectors++;
      if ({RSP_ID, RSP_RDATA} !== {exp_rsp.id, exp_rsp.data}) begin
        miscompares++;
        $display("[TB] FAIL parallel_rsp: got id=%0d data=%h, want id=%0d data=%h",
                 RSP_ID, RSP_RDATA, exp_rsp.id, exp_rsp.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_req(0, 1'b1, 1'b0, 6'd5, '0);
    set_req(1, 1'b1, 1'b0, 6'd9, '0);
    #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        vectors++;
        if (!(RSP_VALID === 1'b1 && sb_q.size() != 0)) begin
          miscompares++;
          $display("[TB] FAIL b2b_rsp_valid %0d: got %b (queued %0d), want 1", c, RSP_VALID, sb_q.size());
        end else begin
          exp_rsp = sb_q.pop_front();
          vectors++;
          if ({RSP_ID, RSP_RDATA} !== {exp_rsp.id, exp_rsp.data}) begin
            miscompares++;
            $display("[TB] FAIL b2b_rsp %0d: got id=%0d data=%h, want id=%0d data=%h",
                     c, RSP_ID, RSP_RDATA, exp_rsp.id, exp_rsp.data);
          end
        end
      end
      if (c < 2) begin
        vectors++;
        if ({REQ_READY, MEM_RE, MEM_RADDR} !== {(c == 0) ? 2'b01 : 2'b10, 1'b1, (c == 0) ? 6'd5 : 6'd9}) begin
          miscompares++;
          $display("[TB] FAIL b2b_issue %0d: got ready=%b re=%b raddr=%0d", c, REQ_READY, MEM_RE, MEM_RADDR);
        end
        sb_q.push_back('{id: 1'(c), data: model_mem[(c == 0) ? 5 : 9]});
        tick();
        REQ_VALID[c] = 1'b0;
        #1;
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b1, 1'b0, 6'd5, '0);
    set_req(1, 1'b1, 1'b1, 6'd30, 64'h3030_3030_3030_3030);
    #1;
    vectors++;
    if (REQ_READY !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL midflight_issue: got ready=%b, want 11", REQ_READY);
    end
    tick();
    vectors++;
    if ({RSP_VALID, REQ_READY} !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL midflight_pending: got rv=%b ready=%b, want rv=1 ready=11", RSP_VALID, REQ_READY);
    end
    RST_N = 1'b0;
    #1;
    vectors++;
    if ({RSP_VALID, REQ_READY, MEM_WE, MEM_RE, INIT_DONE} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL midflight_async_reset: got rv=%b ready=%b we=%b re=%b done=%b, want all 0",
               RSP_VALID, REQ_READY, MEM_WE, MEM_RE, INIT_DONE);
    end
    sb_q.delete();
    REQ_VALID = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    tick();
    test_init_sweep("midflight");
    test_readback(6'd5, 6'd30, 6'd9);
  endtask

  task automatic test_scan_clr();
    set_req(0, 1'b1, 1'b1, 6'd40, 64'h4040_4040_4040_4040);
    set_req(1, 1'b1, 1'b0, 6'd41, '0);
    SCAN_EN = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({MEM_SE, REQ_READY, MEM_WE, MEM_RE, INIT_DONE} !== {1'b1, 2'b00, 1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL scan_freeze %0d: got se=%b ready=%b we=%b re=%b done=%b, want se=1 ready=00 we=0 re=0 done=1",
                 c, MEM_SE, REQ_READY, MEM_WE, MEM_RE, INIT_DONE);
      end
      if (c > 0) begin
        vectors++;
        if (RSP_VALID !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL scan_rsp %0d: got %b, want 0", c, RSP_VALID);
        end
      end
      tick();
    end
    SCAN_EN = 1'b0;
    #1;
    vectors++;
    if ({MEM_SE, REQ_READY, MEM_WE, MEM_RE} !== {1'b0, 2'b11, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL scan_resume: got se=%b ready=%b we=%b re=%b, want se=0 ready=11 we=1 re=1",
               MEM_SE, REQ_READY, MEM_WE, MEM_RE);
    end
    sb_q.push_back('{id: 1'b1, data: model_mem[41]});
    tick();
    model_mem[40] = 64'h4040_4040_4040_4040;
    REQ_VALID = '0;
    #1;
    vectors++;
    if (!(RSP_VALID === 1'b1 && sb_q.size() != 0)) begin
      miscompares++;
      $display("[TB] FAIL scan_resume_rsp_valid: got %b (queued %0d), want 1", RSP_VALID, sb_q.size());
    end else begin
      exp_rsp = sb_q.pop_front();
      vectors++;
      if ({RSP_ID, RSP_RDATA} !== {exp_rsp.id, exp_rsp.data}) begin
        miscompares++;
        $display("[TB] FAIL scan_resume_rsp: got id=%0d data=%h, want id=%0d data=%h",
                 RSP_ID, RSP_RDATA, exp_rsp.id, exp_rsp.data);
      end
    end
    set_req(0, 1'b1, 1'b1, 6'd50, 64'h5050_5050_5050_5050);
    CLR = 1'b1;
    #1;
    vectors++;
    if ({REQ_READY, MEM_WE, INIT_DONE} !== {2'b00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL clr_no_grant: got ready=%b we=%b done=%b, want ready=00 we=0 done=1",
               REQ_READY, MEM_WE, INIT_DONE);
    end
    tick();
    CLR = 1'b0;
    REQ_VALID = '0;
    test_init_sweep("clr");
    test_readback(6'd40, 6'd50, 6'd63);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fill        = 1'b0;
    $display("[TB] starting scm_port_arbiter bench");
    test_reset();
    test_readback(6'd0, 6'd31, 6'd63);
    test_write_rr();
    test_collision();
    test_parallel();
    test_back_to_back();
    test_reset_midflight();
    test_scan_clr();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d outstanding, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scm_port_arbiter.md
Name: scm_port_arbiter

Overview:
- Controller sitting in front of the 1R1W standard-cell memory (scm65 class: CLK, DIN, DOUT, RADDR, RE, SE, WADDR, WE).
- Shares the memory's single write port and single read port among NREQ requesters using independent round-robin arbitration per port, with valid/ready handshakes.
- Zero-initialises every row after reset or on request, and resolves same-address read/write collisions.

Parameters:
NREQ, 2, number of requesters (>=2)
ADDR_WIDTH, 6, memory address width; NUM_ROWS = 2**ADDR_WIDTH
DATA_WIDTH, 64, memory word width
IDW, $clog2(NREQ), requester-id width (minimum 1)

Ports:
CLK  in  1  single clock; all state updates on posedge
RST_N  in  1  asynchronous, active-low reset
SCAN_EN  in  1  scan mode; forwarded to MEM_SE; freezes arbiter
CLR  in  1  re-initialise request (level, sampled in RUN)
REQ_VALID  in  NREQ  per-requester request valid
REQ_WE  in  NREQ  per-requester: 1 = write, 0 = read
REQ_ADDR  in  NREQ*ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
REQ_WDATA  in  NREQ*DATA_WIDTH  packed write data
REQ_READY  out  NREQ  per-requester accept (combinational)
RSP_VALID  out  1  read data valid
RSP_ID  out  IDW  requester owning RSP_RDATA
RSP_RDATA  out  DATA_WIDTH  read data (= MEM_DOUT)
INIT_DONE  out  1  high in RUN state
MEM_WE, MEM_RE, MEM_SE  out  1  memory enables
MEM_WADDR, MEM_RADDR  out  ADDR_WIDTH  memory addresses
MEM_DIN  out  DATA_WIDTH  memory write data
MEM_DOUT  in  DATA_WIDTH  memory read data

Behaviour:
- FSM states: IDLE, INIT, RUN.
  - IDLE -> INIT unconditionally.
  - INIT -> RUN after the write to row NUM_ROWS-1.
  - RUN -> INIT when CLR=1 (no grants in that cycle).
- Reset (async, RST_N=0) applies immediately and asynchronously, including mid-transaction: state=IDLE, init counter=0, both RR pointers=0, RSP_VALID=0, RSP_ID=0, INIT_DONE=0, REQ_READY=0, MEM_WE=0, MEM_RE=0. No in-flight response survives reset.
- IDLE: all memory enables 0.
- INIT:
  - MEM_WE=1, MEM_WADDR=counter, MEM_DIN=0, MEM_RE=0.
  - Counter increments each cycle from 0 to NUM_ROWS-1; total NUM_ROWS cycles.
  - REQ_READY=0 throughout.
- RUN:
  - Write class = {i : REQ_VALID[i] & REQ_WE[i]}; read class = {i : REQ_VALID[i] & ~REQ_WE[i]}.
  - Each class has its own RR pointer. Winner = first requester at or after the pointer (wrapping).
  - After a grant, that class's pointer = winner+1 mod NREQ; it is unchanged when there is no grant.
  - Issue is combinational, same cycle: MEM_WE/WADDR/DIN from the write winner, MEM_RE/RADDR from the read winner. The memory performs the operation at the closing posedge, which is also the handshake edge (REQ_VALID & REQ_READY).
  - At most one write and one read accepted per cycle; different requesters may win each class simultaneously.
  - Collision: if both winners exist and the write address equals the read address, the write is granted and the read is stalled (READY=0, read pointer held). The read retries next cycle and returns the new data.
  - Read response: RSP_VALID=1 and RSP_ID=winner in the cycle after the accept edge (registered); RSP_RDATA = MEM_DOUT in that cycle. One response per accepted read; no backpressure on responses.
- SCAN_EN=1, any state: MEM_SE=1, MEM_WE=MEM_RE=0, REQ_READY=0, FSM/counter/pointers frozen, RSP_VALID=0 on the next edge. When SCAN_EN falls, operation resumes where it stopped.
- Requesters must hold REQ_VALID, REQ_WE, REQ_ADDR and REQ_WDATA stable until accepted; the arbiter does not check this.
- MEM_WADDR, MEM_DIN and MEM_RADDR are don't-care when the matching enable is 0; the bench must not check them.

Test Plan:
1. Release RST_N → one IDLE cycle; then 64 cycles of MEM_WE=1 with MEM_WADDR 0..63 and MEM_DIN=0; INIT_DONE rises on the next edge; REQ_READY=0 until then; subsequent reads of any row return 0.
2. RUN, req0 and req1 both write (addrs 5 and 9) and are held → req0 accepted first (MEM_WADDR=5), req1 accepted next cycle (MEM_WADDR=9); write pointer ends at 0.
3. req0 writes addr 3 data 0xA5A5…, req1 reads addr 3 in the same cycle → write accepted, READY[1]=0; read accepted the next cycle; response one cycle later has RSP_VALID=1, RSP_ID=1, RSP_RDATA=0xA5A5….
4. req0 writes addr 10, req1 reads addr 20 in the same cycle → both accepted that cycle; RSP_ID=1 with the prior row-20 contents.
5. Drop RST_N mid-traffic → RSP_VALID, REQ_READY, MEM_WE and MEM_RE go to 0 immediately; after release a full 64-row zero sweep occurs before INIT_DONE.
6. Raise SCAN_EN for 5 cycles in RUN → MEM_SE=1 and no accepts; then pulse CLR for 1 cycle → INIT re-sweep of 64 rows, INIT_DONE low during it, and all rows read 0 afterwards.
